// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester indices and the default byte address of memory word 0.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational base/alignment/range check for a memory-mapped word array.
// Produces addr_ok and the word index (byte offset from BASE_ADDR >> 2).
module dmem_addr_check #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 'h1001_0000,
    localparam int                   IDX_W        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
    input  logic [DATA_WIDTH-1:0] addr_i,
    output logic                  addr_ok_o,
    output logic [IDX_W-1:0]      word_idx_o
);

    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] word;

    // Offset wraps for addresses below base; the base compare masks that case.
    always_comb begin
        offset     = addr_i - BASE_ADDR;
        word       = offset >> 2;
        addr_ok_o  = (addr_i >= BASE_ADDR) && (addr_i[1:0] == 2'b00) &&
                     (word < DATA_WIDTH'(MEMORY_DEPTH));
        word_idx_o = word[IDX_W-1:0];
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the CPU
// load/store path (requester 0) and a loader/debug port (requester 1).
// Each access runs IDLE -> ACCESS -> DONE; ack/err/rdata pulse in DONE.
// Optional build macro DMEM_ARB_FIXED_PRIORITY_EN: requester 0 wins every
// tie instead of round-robin.
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    input  logic [DATA_WIDTH-1:0] mem_ReadData
);

    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    dmem_arb_state_e       state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  addr_ok;
    logic [IDX_W-1:0]      unused_word_idx;

    // Route the granted requester's command toward the memory side.
    always_comb begin
        sel_we    = (grant_q == REQ_LDR) ? we1    : we0;
        sel_addr  = (grant_q == REQ_LDR) ? addr1  : addr0;
        sel_wdata = (grant_q == REQ_LDR) ? wdata1 : wdata0;
    end

    dmem_addr_check #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .BASE_ADDR    (BASE_ADDR)
    ) u_addr_check (
        .addr_i     (sel_addr),
        .addr_ok_o  (addr_ok),
        .word_idx_o (unused_word_idx)
    );

    // State, grant and response registers; reset forces IDLE and aborts any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= REQ_CPU;
            last_grant_q <= REQ_LDR;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Arbitration in IDLE, memory strobes and response capture in ACCESS.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        mem_Address   = '0;
        mem_WriteData = '0;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
                    grant_d = REQ_CPU;
`else
                    grant_d = ~last_grant_q;
`endif
                    state_d = ACCESS;
                end else if (req0) begin
                    grant_d = REQ_CPU;
                    state_d = ACCESS;
                end else if (req1) begin
                    grant_d = REQ_LDR;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_Address   = sel_addr;
                mem_WriteData = sel_wdata;
                mem_MemWrite  = sel_we && addr_ok;
                mem_MemRead   = !sel_we && addr_ok;
                rdata_d       = (!sel_we && addr_ok) ? mem_ReadData : '0;
                err_d         = !addr_ok;
                last_grant_d  = grant_q;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response to the granted requester only during DONE; zero elsewhere.
    always_comb begin
        ack0   = (state_q == DONE) && (grant_q == REQ_CPU);
        ack1   = (state_q == DONE) && (grant_q == REQ_LDR);
        err0   = ack0 && err_q;
        err1   = ack1 && err_q;
        rdata0 = ack0 ? rdata_q : '0;
        rdata1 = ack1 ? rdata_q : '0;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed vector table,
// reset/tie sequences, and randomized traffic against a transaction-level
// reference (reference memory array plus arbitration rule).
module tb_data_memory_arbiter;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, mem_MemWrite, mem_MemRead;
    logic [31:0] rdata0, rdata1, mem_Address, mem_WriteData, mem_ReadData;

    int checks = 0;
    int errors = 0;

    data_memory_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .ack0          (ack0),
        .ack1          (ack1),
        .err0          (err0),
        .err1          (err1),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_ReadData  (mem_ReadData)
    );

    always #5 clk = ~clk;

    // Plain arithmetic statement of the address acceptance rule.
    function automatic bit addr_valid(input logic [31:0] a);
        longint unsigned off;
        if (a < BASE) return 1'b0;
        if ((a % 4) != 0) return 1'b0;
        off = longint'(a) - longint'(BASE);
        return (off / 4) < DEPTH;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    // Environment memory: asynchronous read, write on rising edge.
    logic [31:0] mem [DEPTH] = '{default: '0};
    int wr_cnt = 0, rd_cnt = 0, bad_strobe = 0;

    always_comb begin
        mem_ReadData = 32'hBAD0_BAD0;
        if (addr_valid(mem_Address)) mem_ReadData = mem[word_of(mem_Address)];
    end

    always @(posedge clk) begin
        if (mem_MemWrite) begin
            wr_cnt <= wr_cnt + 1;
            if (addr_valid(mem_Address)) mem[word_of(mem_Address)] <= mem_WriteData;
            else bad_strobe <= bad_strobe + 1;
        end
        if (mem_MemRead) begin
            rd_cnt <= rd_cnt + 1;
            if (!addr_valid(mem_Address)) bad_strobe <= bad_strobe + 1;
        end
    end

    // Reference state
    logic [31:0] ref_mem [DEPTH] = '{default: '0};
    bit          model_last = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit r, input bit v, input bit we, input logic [31:0] a,
                           input logic [31:0] d);
        if (r) begin req1 = v; we1 = we; addr1 = a; wdata1 = d; end
        else begin req0 = v; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_quiet"}, {30'd0, ack0, ack1} | {30'd0, err0, err1}
                              | rdata0 | rdata1, 32'd0);
    endtask

    typedef struct {
        bit          r;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    // One isolated transaction; checks latency, response and strobe counts.
    task automatic run_vec(input string name, input vec_t v);
        int  w0, rd0, k;
        bit  got;
        logic a_me, a_other, e_me, e_other;
        logic [31:0] d_me, d_other;
        w0 = wr_cnt; rd0 = rd_cnt; k = 0; got = 1'b0;
        a_me = 0; a_other = 0; e_me = 0; e_other = 0; d_me = 0; d_other = 0;
        set_req(v.r, 1'b1, v.we, v.addr, v.wdata);
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (ack0 || ack1) begin
                got     = 1'b1;
                a_me    = v.r ? ack1 : ack0;
                a_other = v.r ? ack0 : ack1;
                e_me    = v.r ? err1 : err0;
                e_other = v.r ? err0 : err1;
                d_me    = v.r ? rdata1 : rdata0;
                d_other = v.r ? rdata0 : rdata1;
            end
        end
        set_req(v.r, 1'b0, 1'b0, '0, '0);
        chk({name, "_acked"}, 32'(got), 32'd1);
        chk({name, "_latency"}, k, 2);
        chk({name, "_ack"}, {30'd0, a_me, a_other}, 32'b10);
        chk({name, "_err"}, {30'd0, e_me, e_other}, {30'd0, v.exp_err, 1'b0});
        chk({name, "_rdata"}, d_me, v.exp_rdata);
        chk({name, "_rdata_other"}, d_other, 32'd0);
        chk({name, "_writes"}, wr_cnt - w0, v.exp_wr);
        chk({name, "_reads"}, rd_cnt - rd0, v.exp_rd);
        @(negedge clk);
        check_quiet(name);
        model_last = v.r;
        if (v.we && !v.exp_err) ref_mem[word_of(v.addr)] = v.wdata;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'(4 * $urandom_range(1, 8));
            1:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            2:       return BASE + 32'(4 * (DEPTH + $urandom_range(0, 15)));
            3:       return BASE + 32'(4 * (DEPTH - 4 + $urandom_range(0, 3)));
            default: return BASE + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    vec_t vecs [10];

    initial begin
        vecs[0] = '{0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 0, 32'h0,         1, 0};
        vecs[1] = '{0, 0, 32'h1001_0008, 32'h0,         0, 32'hDEAD_BEEF, 0, 1};
        vecs[2] = '{1, 1, 32'h1000_FFFC, 32'h1111_1111, 1, 32'h0,         0, 0};
        vecs[3] = '{1, 1, 32'h1001_0002, 32'h2222_2222, 1, 32'h0,         0, 0};
        vecs[4] = '{1, 1, 32'h1001_1000, 32'h3333_3333, 1, 32'h0,         0, 0};
        vecs[5] = '{1, 1, 32'h1001_0FFC, 32'h1234_5678, 0, 32'h0,         1, 0};
        vecs[6] = '{1, 0, 32'h1001_0FFC, 32'h0,         0, 32'h1234_5678, 0, 1};
        vecs[7] = '{0, 0, 32'h1001_0FFC, 32'h0,         0, 32'h1234_5678, 0, 1};
        vecs[8] = '{1, 0, 32'h1001_1000, 32'h0,         1, 32'h0,         0, 0};
        vecs[9] = '{0, 0, 32'h1001_0000, 32'h0,         0, 32'h0,         0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_strobes", {30'd0, mem_MemWrite, mem_MemRead}, 32'd0);
        chk("rst_addr", mem_Address | mem_WriteData, 32'd0);
        check_quiet("rst");
        reset = 1'b1;
        @(negedge clk);

        // Tie: both requesters hold req for three transactions each
        begin
            int  idx [2];
            int  n, k, prev_k;
            bit  order [6];
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
            order = '{0, 0, 0, 1, 1, 1};
`else
            order = '{0, 1, 0, 1, 0, 1};
`endif
            idx[0] = 0; idx[1] = 0; n = 0; k = 0; prev_k = 0;
            set_req(0, 1, 1, BASE + 32'(4 * 100), 32'hA000_0000);
            set_req(1, 1, 1, BASE + 32'(4 * 200), 32'hB000_0000);
            while (n < 6 && k < 40) begin
                @(negedge clk);
                k++;
                if (ack0 && ack1) chk("tie_single_ack", 32'd2, 32'd1);
                else if (ack0 || ack1) begin
                    bit r;
                    r = ack1;
                    chk($sformatf("tie_order%0d", n), 32'(r), 32'(order[n]));
                    chk($sformatf("tie_time%0d", n), k - prev_k, (n == 0) ? 2 : 3);
                    chk($sformatf("tie_err%0d", n), {31'd0, err0 | err1}, 32'd0);
                    ref_mem[(r ? 200 : 100) + idx[r]] = (r ? 32'hB000_0000 : 32'hA000_0000)
                                                        + 32'(idx[r]);
                    prev_k = k;
                    model_last = r;
                    idx[r]++;
                    n++;
                    if (idx[r] == 3) set_req(r, 0, 0, '0, '0);
                    else set_req(r, 1, 1, BASE + 32'(4 * ((r ? 200 : 100) + idx[r])),
                                 (r ? 32'hB000_0000 : 32'hA000_0000) + 32'(idx[r]));
                end
            end
            chk("tie_all_acked", n, 6);
            set_req(0, 0, 0, '0, '0);
            set_req(1, 0, 0, '0, '0);
            @(negedge clk);
            chk("tie_mem_r0_last", mem[102], 32'hA000_0002);
            chk("tie_mem_r1_last", mem[202], 32'hB000_0002);
        end

        // Directed vector table
        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset mid-ACCESS of a store aborts it
        begin
            int w0;
            w0 = wr_cnt;
            set_req(0, 1, 1, 32'h1001_0004, 32'hCAFE_F00D);
            @(negedge clk);
            chk("midrst_write_strobe_before", {31'd0, mem_MemWrite}, 32'd1);
            reset = 1'b0;
            #1;
            chk("midrst_strobes", {30'd0, mem_MemWrite, mem_MemRead}, 32'd0);
            chk("midrst_bus", mem_Address | mem_WriteData, 32'd0);
            check_quiet("midrst");
            set_req(0, 0, 0, '0, '0);
            @(negedge clk);
            check_quiet("midrst_hold");
            reset = 1'b1;
            model_last = 1'b1;
            @(negedge clk);
            chk("midrst_no_write", wr_cnt - w0, 0);
            chk("midrst_mem", mem[1], 32'd0);
            run_vec("midrst_load", '{0, 0, 32'h1001_0004, 32'h0, 0, 32'h0, 0, 1});
        end

        // Randomized traffic against the reference model
        for (int round = 0; round < 80; round++) begin
            bit          act [2];
            bit          rwe [2];
            logic [31:0] radr [2];
            logic [31:0] rwd [2];
            bit          order [2];
            int          nexp, n, k, w0, exp_w;
            int          mask;
            mask = int'($urandom_range(1, 3));
            exp_w = 0;
            w0 = wr_cnt;
            for (int r = 0; r < 2; r++) begin
                act[r]  = mask[r];
                rwe[r]  = $urandom_range(0, 1) == 1;
                radr[r] = rand_addr();
                rwd[r]  = $urandom;
                if (act[r]) set_req(r[0], 1, rwe[r], radr[r], rwd[r]);
            end
            if (mask == 3) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
                order[0] = 1'b0;
`else
                order[0] = !model_last;
`endif
                order[1] = !order[0];
                nexp = 2;
            end else begin
                order[0] = (mask == 2);
                order[1] = 1'b0;
                nexp = 1;
            end
            n = 0; k = 0;
            while (n < nexp && k < 20) begin
                @(negedge clk);
                k++;
                if (ack0 && ack1) chk("rnd_single_ack", 32'd2, 32'd1);
                else if (ack0 || ack1) begin
                    bit          r;
                    bit          ok;
                    logic [31:0] exp_d;
                    r  = ack1;
                    ok = addr_valid(radr[r]);
                    exp_d = (!rwe[r] && ok) ? ref_mem[word_of(radr[r])] : 32'd0;
                    chk($sformatf("rnd%0d_who%0d", round, n), 32'(r), 32'(order[n]));
                    chk($sformatf("rnd%0d_lat%0d", round, n), k, 2 + 3 * n);
                    chk($sformatf("rnd%0d_err%0d", round, n), {31'd0, r ? err1 : err0},
                        {31'd0, !ok});
                    chk($sformatf("rnd%0d_rdata%0d", round, n), r ? rdata1 : rdata0, exp_d);
                    if (rwe[r] && ok) begin
                        ref_mem[word_of(radr[r])] = rwd[r];
                        exp_w++;
                    end
                    model_last = r;
                    set_req(r, 0, 0, '0, '0);
                    n++;
                end
            end
            chk($sformatf("rnd%0d_done", round), n, nexp);
            set_req(0, 0, 0, '0, '0);
            set_req(1, 0, 0, '0, '0);
            @(negedge clk);
            chk($sformatf("rnd%0d_writes", round), wr_cnt - w0, exp_w);
            check_quiet($sformatf("rnd%0d", round));
        end

        chk("illegal_strobes", bad_strobe, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port MIPS data memory between the CPU load/store path (requester 0) and a memory loader/debug port (requester 1). It sits between the requesters and the data memory. It performs round-robin arbitration and the base-address/alignment/range check, then sequences each access through a 3-state FSM with a req/ack handshake. Read data and error status are registered back to the granted requester.

## Interface
- DATA_WIDTH, 32, data and address width
- MEMORY_DEPTH, 1024, number of words in the data memory
- BASE_ADDR, 32'h1001_0000, byte address of memory word 0

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request; held high until the matching ack
- we0, we1  in  1  1 = store, 0 = load; stable while req is high
- addr0, addr1  in  DATA_WIDTH  byte address; stable while req is high
- wdata0, wdata1  in  DATA_WIDTH  store data; stable while req is high
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  high together with ack when the access was rejected
- rdata0, rdata1  out  DATA_WIDTH  registered load data, valid while ack is high
- mem_Address  out  DATA_WIDTH  to memory Address
- mem_WriteData  out  DATA_WIDTH  to memory WriteData
- mem_MemWrite, mem_MemRead  out  1  to memory strobes
- mem_ReadData  in  DATA_WIDTH  from memory ReadData

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not `last_grant`. `last_grant` resets to 1, so requester 0 wins the first tie.
  - On a grant, latch `grant` and go to ACCESS.
- **ACCESS**
  - mem_Address, mem_WriteData and we are muxed combinationally from the granted requester.
  - `addr_ok` = (addr ≥ BASE_ADDR) && (addr[1:0] == 0) && (((addr − BASE_ADDR) >> 2) < MEMORY_DEPTH). The subtraction is DATA_WIDTH wide, unsigned.
  - mem_MemWrite = we && addr_ok.
  - mem_MemRead = !we && addr_ok.
  - At the clock edge ending ACCESS:
    - capture mem_ReadData into the rdata register, or 0 for a store or a rejected access;
    - set the err register to !addr_ok;
    - update last_grant to grant;
    - go to DONE.
- **DONE**
  - ack of the granted requester is 1; the other ack is 0.
  - err of the granted requester equals the err register.
  - The granted rdata output drives the captured word.
  - Always return to IDLE.
- Outside DONE, all ack, err and rdata outputs are 0.
- A rejected access never asserts mem_MemWrite or mem_MemRead.
- If req drops during ACCESS, the transaction still completes and ack still pulses. The requester must ignore that ack.
- Reset mid-operation: the FSM goes to IDLE immediately, mem strobes go low combinationally, and any pending write is aborted.

## Timing
- Reset values: ack0/1 = 0, err0/1 = 0, rdata0/1 = 0, mem_MemWrite = 0, mem_MemRead = 0, mem_Address = 0, mem_WriteData = 0, last_grant = 1.
- Cycle timeline for a req seen in IDLE at edge N:
  - ACCESS runs from N to N+1;
  - the store commits to memory at edge N+1;
  - ack/rdata/err are visible from N+1 to N+2.
- Latency is 2 cycles from req sampled to ack. Throughput is 1 transaction per 3 cycles.
- A requester holding req through its ack cycle is not re-granted in that cycle, because arbitration happens only in IDLE. It must drop req the cycle after ack unless it issues a new request.
- The loser of a tie waits one full transaction (3 cycles) and is granted at the next IDLE.

## Configuration
- DMEM_ARB_FIXED_PRIORITY_EN
  - Defined: requester 0 wins every tie; last_grant is not used for arbitration.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Package `dmem_arb_pkg`:
  - state encoding constants IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - requester index constants REQ_CPU = 0, REQ_LDR = 1;
  - default BASE_ADDR.
- Sub-module `dmem_addr_check`: purely combinational. It takes addr and produces addr_ok and the word index, so the range check is reusable by other memory-mapped blocks.
- Top module contains the FSM, arbitration, the response registers and the output muxes.

## Test plan
- Reset: assert reset low mid-ACCESS of a store to 0x1001_0004 → strobes drop immediately, no write occurs, all outputs 0, FSM in IDLE.
- Single store then load:
  - req0 store 0xDEADBEEF to 0x1001_0008 → mem_MemWrite high for exactly 1 cycle, ack0 2 cycles after req;
  - req0 load from 0x1001_0008 → rdata0 = 0xDEADBEEF with ack0, err0 = 0.
- Tie, round-robin: req0 and req1 asserted together, held for 3 transactions each → grants in order 0, 1, 0, 1, 0, 1, with each ack 3 cycles apart.
- Tie, with DMEM_ARB_FIXED_PRIORITY_EN defined: same stimulus → all three req0 transactions complete before the first req1 ack.
- Error cases, each giving ack1 = 1, err1 = 1, rdata1 = 0 and no memory strobe:
  - req1 store to 0x1000_FFFC (below base);
  - req1 store to 0x1001_0002 (misaligned);
  - req1 store to 0x1001_1000 (index 1024).
- Boundary: load from 0x1001_0FFC (index 1023), previously written with 0x12345678 → data returned, err = 0.
